// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - HI/LO multiply/divide controller with restoring divider and flush/stall handling
module hilo_muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [4:0] MUL_LAST = (MUL_LAT > 1) ? 5'(MUL_LAT - 2) : 5'd0;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] rem_q, rem_d;
    logic        sgn_q, sgn_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = {{32{sgn & a[31]}}, a};
        eb = {{32{sgn & b[31]}}, b};
        return ea * eb;
    endfunction

    // During DIV, a_q holds the dividend shifting out while quotient bits shift in.
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [31:0] div_rem;
    logic [31:0] div_quo;
    logic [63:0] mul_prod;
    logic [63:0] start_prod;

    assign div_shift  = {rem_q, a_q[31]};
    assign div_diff   = div_shift - {1'b0, b_q};
    assign div_rem    = div_diff[32] ? div_shift[31:0] : div_diff[31:0];
    assign div_quo    = {a_q[30:0], ~div_diff[32]};
    assign mul_prod   = mul64(a_q, b_q, sgn_q);
    assign start_prod = mul64(a_i, b_i, op_i == OP_MULT);

    assign hi_o = hi_q;
    assign lo_o = lo_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        sgn_d   = sgn_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        stall_o = 1'b0;
        done_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = 5'd0;
                if (start_i && !flush_i) begin
                    case (op_i)
                        OP_MTHI: hi_d = a_i;
                        OP_MTLO: lo_d = a_i;
                        OP_MULT, OP_MULTU: begin
                            a_d   = a_i;
                            b_d   = b_i;
                            sgn_d = (op_i == OP_MULT);
                            if (MUL_LAT == 1) begin
                                {hi_d, lo_d} = start_prod;
                                done_o       = 1'b1;
                            end else begin
                                state_d = S_MUL;
                                stall_o = 1'b1;
                            end
                        end
                        OP_DIV, OP_DIVU: begin
                            sgn_d   = (op_i == OP_DIV);
                            a_d     = (sgn_d && a_i[31]) ? -a_i : a_i;
                            b_d     = (sgn_d && b_i[31]) ? -b_i : b_i;
                            rem_d   = 32'd0;
                            qneg_d  = sgn_d & (a_i[31] ^ b_i[31]);
                            rneg_d  = sgn_d & a_i[31];
                            state_d = S_DIV;
                            stall_o = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            S_MUL: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                    cnt_d   = 5'd0;
                end else if (cnt_q == MUL_LAST) begin
                    {hi_d, lo_d} = mul_prod;
                    done_o       = 1'b1;
                    state_d      = S_IDLE;
                    cnt_d        = 5'd0;
                end else begin
                    stall_o = 1'b1;
                    cnt_d   = cnt_q + 5'd1;
                end
            end

            S_DIV: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                    cnt_d   = 5'd0;
                end else if (cnt_q == 5'd31) begin
                    // A zero divisor still takes the full latency but leaves HI/LO alone.
                    if (b_q != 32'd0) begin
                        hi_d = rneg_q ? -div_rem : div_rem;
                        lo_d = qneg_q ? -div_quo : div_quo;
                    end
                    done_o  = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = 5'd0;
                end else begin
                    stall_o = 1'b1;
                    rem_d   = div_rem;
                    a_d     = div_quo;
                    cnt_d   = cnt_q + 5'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            rem_q   <= 32'd0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: doc/hilo_muldiv_ctrl.md
HILO_MULDIV_CTRL -- requirements
Module: hilo_muldiv_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 2, meaning multiply latency in cycles (legal 1..4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_i  input  1  operation request valid.
REQ-005 SHALL have port op_i  input  3  operation: 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; other codes are no-op.
REQ-006 SHALL have port a_i  input  32  rs operand (dividend / multiplicand / MTHI-MTLO source).
REQ-007 SHALL have port b_i  input  32  rt operand (divisor / multiplier).
REQ-008 SHALL have port flush_i  input  1  exception/flush; aborts any operation.
REQ-009 SHALL have port stall_o  output  1  pipeline stall request.
REQ-010 SHALL have port done_o  output  1  one-cycle pulse; HI/LO written at the end of this cycle.
REQ-011 SHALL have port hi_o  output  32  architectural HI register.
REQ-012 SHALL have port lo_o  output  32  architectural LO register.

Function
REQ-013 SHALL implement states IDLE, MUL, DIV; start_i is sampled only in IDLE.
REQ-014 SHALL, in IDLE with start_i and op MTHI/MTLO, write a_i to HI/LO at that edge with no stall, done_o low, state stays IDLE.
REQ-015 SHALL, in IDLE with start_i and op MULT/MULTU, latch operands and enter MUL; if MUL_LAT=1, write HI/LO at that same edge and pulse done_o without entering MUL.
REQ-016 SHALL, for MUL, write {HI,LO} = 64-bit product (signed for MULT, unsigned for MULTU) at the edge ending cycle T+MUL_LAT-1, with T the start cycle; done_o high in that cycle; return to IDLE.
REQ-017 SHALL, in IDLE with start_i and op DIV/DIVU, latch operand magnitudes, quotient sign (a[31]^b[31], DIV only), and remainder sign (a[31], DIV only), then enter DIV.
REQ-018 SHALL perform 32 radix-2 restoring iterations, one per cycle, with a 5-bit counter, in cycles T+1..T+32; HI=remainder and LO=quotient, sign-corrected, written at the edge ending T+32; done_o high in T+32.
REQ-019 SHALL, for divisor zero, run the full latency, pulse done_o, and leave HI/LO unchanged.
REQ-020 SHALL produce LO=0x80000000, HI=0 for DIV 0x80000000 / 0xFFFFFFFF, with no trap.
REQ-021 SHALL drive stall_o combinationally high in IDLE when start_i && op is MULT/MULTU/DIV/DIVU && !flush_i, high throughout MUL/DIV, and low in the done_o cycle.
REQ-022 SHALL, on flush_i in MUL/DIV, abort with HI/LO unchanged, done_o low, stall_o low in that cycle, and return to IDLE at the next edge.
REQ-023 SHALL ignore start_i when flush_i is asserted in the same cycle, including MTHI/MTLO.
REQ-024 SHALL ignore start_i while in MUL/DIV.
REQ-025 SHALL ignore op_i, a_i and b_i after the start cycle, since operands are latched.
REQ-026 SHALL drive hi_o/lo_o directly from registers, so writes are visible the cycle after the write edge.

Reset
REQ-027 SHALL, on resetn low, immediately force state IDLE, hi_o=0, lo_o=0, done_o=0, stall_o=0, counter=0, and clear latched operands.
REQ-028 SHALL, on reset mid-operation, discard the operation with no HI/LO write after release.
REQ-029 SHALL accept a new start_i in the first cycle after resetn rises.

Verification
REQ-030 SHALL cover MULT and MULTU with a=0xFFFFFFFF, b=2, MUL_LAT=2 -> MULT: HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU: HI=0x00000001, LO=0xFFFFFFFE; stall_o high 1 cycle, then done_o.
REQ-031 SHALL cover DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, done_o exactly 32 cycles after start; DIVU 100/7 -> LO=0xE, HI=0x2.
REQ-032 SHALL cover divide-by-zero (DIVU 5/0, HI=LO=0x1234 preloaded via MTHI/MTLO) -> done_o at T+32, HI=LO=0x1234.
REQ-033 SHALL cover flush_i at iteration 10 of a DIV -> stall_o drops that cycle, no done_o, HI/LO unchanged, and a MTLO on the next cycle is accepted.
REQ-034 SHALL cover resetn pulsed low mid-MUL with MUL_LAT=4 -> hi_o=lo_o=0 immediately and no done_o afterwards.
REQ-035 SHALL cover start_i with op DIV plus flush_i in the same cycle -> stall_o low and state stays IDLE.
